// File: rtl/sam_mem_pkg.sv
// Shared types and constants for the SAM memory arbiter and its priority picker.
package sam_mem_pkg;

  localparam int MEMARB_AW = 25;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } memarb_state_t;

  typedef enum logic [1:0] {
    ID_DMA,
    ID_FDD,
    ID_CPU
  } memarb_id_t;

  // Completion vector ordered {cpu, fdd, dma} for the granted requester.
  function automatic logic [2:0] memarb_ack_vec(memarb_id_t id);
    logic [2:0] v;
    v = 3'b000;
    case (id)
      ID_DMA:  v = 3'b001;
      ID_FDD:  v = 3'b010;
      ID_CPU:  v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sam_mem_pick.sv
// Combinational winner selection: DMA strictly first, FDD/CPU alternate via last_lo.
module sam_mem_pick
  import sam_mem_pkg::*;
(
  input  logic       dma_req,
  input  logic       fdd_req,
  input  logic       cpu_req,
  input  logic       last_lo,
  output logic       vld,
  output memarb_id_t id
);

  always_comb begin
    vld = dma_req | fdd_req | cpu_req;
    id  = ID_DMA;
    if (dma_req) begin
      id = ID_DMA;
    end else if (fdd_req && cpu_req) begin
      // last_lo set means FDD was served most recently, so the CPU goes next.
      id = last_lo ? ID_CPU : ID_FDD;
    end else if (fdd_req) begin
      id = ID_FDD;
    end else if (cpu_req) begin
      id = ID_CPU;
    end
  end

endmodule

// File: rtl/sam_mem_arbiter.sv
// Single-port arbiter sharing the SDRAM CPU-side port between ioctl DMA, WD1793 FDD and Z80.
// Optional feature: define MEMARB_TIMEOUT_EN to bound the wait for mem_ack and raise a sticky err.
module sam_mem_arbiter
  import sam_mem_pkg::*;
#(
  parameter int AW     = MEMARB_AW,
  parameter int TO_CYC = 255
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_din,
  output logic          dma_ack,
  input  logic          fdd_req,
  input  logic          fdd_we,
  input  logic [AW-1:0] fdd_addr,
  output logic          fdd_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_ack,
  output logic          cpu_wait,
  output logic [7:0]    rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic          mem_ack,
  input  logic [7:0]    mem_dout,
  output logic          busy,
  output logic          err
);

  memarb_state_t state;
  memarb_id_t    lat_id;
  memarb_id_t    pick_id;
  logic          pick_vld;
  logic          last_lo;
  logic [2:0]    ack_vec;

  if (TO_CYC < 1 || TO_CYC > 255) begin : g_to_cyc_range
    $error("sam_mem_arbiter: TO_CYC must lie in 1..255");
  end

  sam_mem_pick u_pick (
    .dma_req (dma_req),
    .fdd_req (fdd_req),
    .cpu_req (cpu_req),
    .last_lo (last_lo),
    .vld     (pick_vld),
    .id      (pick_id)
  );

  assign dma_ack = ack_vec[0];
  assign fdd_ack = ack_vec[1];
  assign cpu_ack = ack_vec[2];

  // Gated by rst_n so the Z80 is never stalled while the arbiter is held in reset.
  assign cpu_wait = rst_n & cpu_req & ~ack_vec[2];

`ifdef MEMARB_TIMEOUT_EN
  localparam logic [7:0] TO_LOAD = 8'(TO_CYC);
  logic [7:0] to_cnt;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_id   <= ID_DMA;
      last_lo  <= 1'b0;
      ack_vec  <= 3'b000;
      busy     <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rdata    <= 8'hFF;
`ifdef MEMARB_TIMEOUT_EN
      to_cnt   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      mem_req <= 1'b0;
      ack_vec <= 3'b000;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            // The strobe fields double as the latch, so later input changes are ignored.
            lat_id  <= pick_id;
            state   <= ISSUE;
            busy    <= 1'b1;
            mem_req <= 1'b1;
            case (pick_id)
              ID_DMA: begin
                mem_addr <= dma_addr;
                mem_we   <= dma_we;
                mem_din  <= dma_din;
              end
              ID_FDD: begin
                mem_addr <= fdd_addr;
                mem_we   <= fdd_we;
                mem_din  <= 8'h00;
              end
              default: begin
                mem_addr <= cpu_addr;
                mem_we   <= cpu_we;
                mem_din  <= cpu_din;
              end
            endcase
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef MEMARB_TIMEOUT_EN
          to_cnt <= TO_LOAD;
`endif
        end
        WAIT: begin
          if (mem_ack) begin
            rdata   <= mem_dout;
            ack_vec <= memarb_ack_vec(lat_id);
            state   <= DONE;
          end
`ifdef MEMARB_TIMEOUT_EN
          else if (to_cnt == 8'd1) begin
            rdata   <= 8'hFF;
            err_q   <= 1'b1;
            ack_vec <= memarb_ack_vec(lat_id);
            state   <= DONE;
          end else begin
            to_cnt <= to_cnt - 8'd1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (lat_id == ID_FDD) begin
            last_lo <= 1'b1;
          end else if (lat_id == ID_CPU) begin
            last_lo <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
